// File: rtl/run_sequence_generator.sv
// -----------------------------------------------------------------------------
// run_sequence_generator
//
// Purpose:
//   Serial stimulus transmitter for the consecutive-ones run detector. It emits
//   a one-bit stream of programmable runs of ones separated by gaps of zeros.
//   Alongside the stream it produces expect_y, the cycle-accurate reference for
//   the detector output. expect_y is high on every w_out=1 cycle that is the
//   THRESH-th or later consecutive one.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   start     in   request pulse, accepted only while ready=1 and reset=0
//   run_len   in   [LEN_W] ones per run, sampled on accept
//   gap_len   in   [LEN_W] zeros per gap, sampled on accept (minimum 1 applied)
//   reps      in   [REP_W] number of run+gap pairs, sampled on accept
//   ready     out  idle (IDLE or FIN), able to accept start
//   busy      out  a burst bit is on w_out this cycle
//   w_out     out  registered serial stream to the detector's w input
//   expect_y  out  registered run-reached-threshold reference
//   done      out  one-cycle pulse after the last bit of a burst
//
// Optional feature (macro RUN_SEQUENCE_GEN_JITTER_EN):
//   Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with LFSR_SEED. It
//   stretches every gap by lfsr[1:0] extra zeros and steps once per completed
//   gap. LFSR_SEED exists only in that build because nothing else uses it.
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for start, ready=1
//   RUN    | w_out=1 this cycle, counting down the run
//   GAP    | w_out=0 this cycle, counting down the gap
//   FIN    | done=1, ready=1 for one cycle; start here is accepted
// -----------------------------------------------------------------------------
module run_sequence_generator #(
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned REP_W  = 4,
  parameter int unsigned THRESH = 4
`ifdef RUN_SEQUENCE_GEN_JITTER_EN
  ,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [REP_W-1:0] reps,
  output logic             ready,
  output logic             busy,
  output logic             w_out,
  output logic             expect_y,
  output logic             done
);

  // One extra bit lets the phase counter hold max(gap_len,1)+3 without
  // wrapping when jitter is enabled.
  localparam int unsigned CNT_W = LEN_W + 1;

  localparam logic [LEN_W-1:0] THRESH_L = LEN_W'(THRESH);
  localparam logic [LEN_W-1:0] ONES_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [REP_W-1:0] rep_q,     rep_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [LEN_W-1:0] gap_len_q, gap_len_d;
  logic [LEN_W-1:0] ones_q,    ones_d;
  logic             w_out_q,   w_out_d;
  logic             expect_q,  expect_d;

  // Extra gap zeros. jit_cur applies to a gap entered while the LFSR holds
  // its current value. jit_nxt applies to a gap that follows a gap directly,
  // because the LFSR steps on that same edge.
  logic [1:0]       jit_cur;
  logic [1:0]       jit_nxt;

`ifdef RUN_SEQUENCE_GEN_JITTER_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_nxt;
  logic       lfsr_fb;

  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_nxt = {lfsr_q[6:0], lfsr_fb};
  assign jit_cur  = lfsr_q[1:0];
  assign jit_nxt  = lfsr_nxt[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q == S_GAP && cnt_q == '0) begin
      lfsr_q <= lfsr_nxt;
    end
  end
`else
  assign jit_cur = 2'b00;
  assign jit_nxt = 2'b00;
`endif

  // Gap length with a floor of one zero, so runs never merge across reps.
  function automatic logic [CNT_W-1:0] gap_eff(input logic [LEN_W-1:0] g,
                                               input logic [1:0]       jit);
    logic [CNT_W-1:0] base;
    base = (g == '0) ? CNT_W'(1) : CNT_W'(g);
    return base + CNT_W'(jit);
  endfunction

  // Counter load values are length-1, so the phase ends when cnt reaches 0.
  logic [CNT_W-1:0] run_load_in;
  logic [CNT_W-1:0] run_load_q;
  logic [CNT_W-1:0] gap_load_in;
  logic [CNT_W-1:0] gap_load_cur;
  logic [CNT_W-1:0] gap_load_nxt;

  assign run_load_in  = CNT_W'(run_len)   - CNT_W'(1);
  assign run_load_q   = CNT_W'(run_len_q) - CNT_W'(1);
  assign gap_load_in  = gap_eff(gap_len,   jit_cur) - CNT_W'(1);
  assign gap_load_cur = gap_eff(gap_len_q, jit_cur) - CNT_W'(1);
  assign gap_load_nxt = gap_eff(gap_len_q, jit_nxt) - CNT_W'(1);

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    run_len_d = run_len_q;
    gap_len_d = gap_len_q;

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (state_q == S_FIN) begin
          state_d = S_IDLE;
        end
        if (start) begin
          run_len_d = run_len;
          gap_len_d = gap_len;
          rep_d     = reps;
          if (reps == '0) begin
            state_d = S_FIN;
          end else if (run_len != '0) begin
            state_d = S_RUN;
            cnt_d   = run_load_in;
          end else begin
            state_d = S_GAP;
            cnt_d   = gap_load_in;
          end
        end
      end

      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = gap_load_cur;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          rep_d = rep_q - REP_W'(1);
          if (rep_q == REP_W'(1)) begin
            state_d = S_FIN;
          end else if (run_len_q != '0) begin
            state_d = S_RUN;
            cnt_d   = run_load_q;
          end else begin
            state_d = S_GAP;
            cnt_d   = gap_load_nxt;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output pipeline. w_out and expect_y are computed from the next state, so
  // both flops change on the same edge as the state register. ones_q holds
  // the run length including the bit currently on w_out.
  always_comb begin
    w_out_d = (state_d == S_RUN);
    ones_d  = '0;
    if (w_out_d) begin
      ones_d = (ones_q == ONES_MAX) ? ONES_MAX : ones_q + LEN_W'(1);
    end
    expect_d = w_out_d && (ones_d >= THRESH_L);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rep_q     <= '0;
      run_len_q <= '0;
      gap_len_q <= '0;
      ones_q    <= '0;
      w_out_q   <= 1'b0;
      expect_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      run_len_q <= run_len_d;
      gap_len_q <= gap_len_d;
      ones_q    <= ones_d;
      w_out_q   <= w_out_d;
      expect_q  <= expect_d;
    end
  end

  // Status outputs decode directly from the state flop.
  assign ready    = (state_q == S_IDLE) || (state_q == S_FIN);
  assign busy     = (state_q == S_RUN)  || (state_q == S_GAP);
  assign done     = (state_q == S_FIN);
  assign w_out    = w_out_q;
  assign expect_y = expect_q;

endmodule

// File: tb/tb_run_sequence_generator.sv
module tb_run_sequence_generator;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] run_len;
  logic [3:0] gap_len;
  logic [3:0] reps;
  logic       ready;
  logic       busy;
  logic       w_out;
  logic       expect_y;
  logic       done;

  int checks = 0;
  int errors = 0;

  run_sequence_generator dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .run_len  (run_len),
    .gap_len  (gap_len),
    .reps     (reps),
    .ready    (ready),
    .busy     (busy),
    .w_out    (w_out),
    .expect_y (expect_y),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(ready, 1'b1, {tag, " ready"});
    chk(busy,  1'b0, {tag, " busy"});
    chk(w_out, 1'b0, {tag, " w_out"});
    chk(expect_y, 1'b0, {tag, " expect_y"});
    chk(done,  1'b0, {tag, " done"});
  endtask

  task automatic idle_cycles(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      tick();
      chk_idle($sformatf("%s idle%0d", tag, i));
    end
  endtask

  // Launches a burst at edge T and checks cycles T+1..T+N+1. Bit i+1 of the
  // burst is wp/yp[n-1-i] (MSB first). Returns while in the FIN cycle so that
  // a following call can exercise back-to-back starts. When poke >= 0, a
  // start with different operands is driven in cycle T+1+poke, which must be
  // ignored.
  task automatic burst(input logic [3:0] rl, input logic [3:0] gl,
                       input logic [3:0] rp, input int n,
                       input logic [31:0] wp, input logic [31:0] yp,
                       input int poke, input string tag);
    start   = 1'b1;
    run_len = rl;
    gap_len = gl;
    reps    = rp;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk(w_out,    wp[n-1-i], $sformatf("%s w_out@T+%0d", tag, i+1));
      chk(expect_y, yp[n-1-i], $sformatf("%s expect_y@T+%0d", tag, i+1));
      chk(busy,  1'b1, $sformatf("%s busy@T+%0d", tag, i+1));
      chk(done,  1'b0, $sformatf("%s done@T+%0d", tag, i+1));
      chk(ready, 1'b0, $sformatf("%s ready@T+%0d", tag, i+1));
      if (i == poke) begin
        start   = 1'b1;
        run_len = 4'd9;
        gap_len = 4'd5;
        reps    = 4'd3;
      end
      tick();
      start = 1'b0;
    end
    chk(done,     1'b1, $sformatf("%s done@T+%0d", tag, n+1));
    chk(ready,    1'b1, $sformatf("%s ready@T+%0d", tag, n+1));
    chk(busy,     1'b0, $sformatf("%s busy@T+%0d", tag, n+1));
    chk(w_out,    1'b0, $sformatf("%s w_out@T+%0d", tag, n+1));
    chk(expect_y, 1'b0, $sformatf("%s expect_y@T+%0d", tag, n+1));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    run_len = '0;
    gap_len = '0;
    reps    = '0;

    tick();
    tick();
    chk_idle("reset");
    reset = 1'b0;
    tick();
    chk_idle("post_reset");

    // Basic burst: 1111 00, threshold reached on the 4th one.
    burst(4'd4, 4'd2, 4'd1, 6, 32'b111100, 32'b000100, -1, "basic");
    idle_cycles(2, "basic");

    // gap_len=0 is forced to one zero; 111110 x3, done at T+19.
    burst(4'd5, 4'd0, 4'd3, 18, 32'b111110111110111110,
          32'b000110000110000110, -1, "repeat");
    idle_cycles(2, "repeat");

    // reps=0: done at T+1, no bits.
    burst(4'd7, 4'd2, 4'd0, 0, 32'b0, 32'b0, -1, "reps0");
    idle_cycles(2, "reps0");

    // run_len=0: two gaps of three zeros, done at T+7.
    burst(4'd0, 4'd3, 4'd2, 6, 32'b000000, 32'b000000, -1, "run0");
    idle_cycles(2, "run0");

    // Runs shorter than THRESH never raise expect_y.
    burst(4'd3, 4'd1, 4'd2, 8, 32'b11101110, 32'b00000000, -1, "short");
    idle_cycles(2, "short");

    // Largest legal run: 15 ones, expect_y on ones 4..15, ones-counter saturates.
    burst(4'd15, 4'd1, 4'd1, 16, 32'b1111111111111110,
          32'b0001111111111110, -1, "maxrun");
    idle_cycles(2, "maxrun");

    // A start pulsed mid-burst (cycle T+2) is ignored.
    burst(4'd4, 4'd2, 4'd1, 6, 32'b111100, 32'b000100, 1, "busy_start");
    idle_cycles(2, "busy_start");

    // Back-to-back: the second start arrives in the FIN cycle of the first.
    burst(4'd2, 4'd1, 4'd1, 3, 32'b110, 32'b000, -1, "b2b_first");
    burst(4'd4, 4'd2, 4'd1, 6, 32'b111100, 32'b000100, -1, "b2b_second");
    idle_cycles(2, "b2b");

    // Reset in cycle T+3 of an 8-long run aborts it. A start held with reset
    // is ignored.
    start   = 1'b1;
    run_len = 4'd8;
    gap_len = 4'd2;
    reps    = 4'd1;
    tick();
    start = 1'b0;
    chk(w_out, 1'b1, "abort w_out@T+1");
    tick();
    chk(w_out, 1'b1, "abort w_out@T+2");
    tick();
    chk(w_out, 1'b1, "abort w_out@T+3");
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk_idle("abort T+4");
    idle_cycles(3, "abort");

    burst(4'd4, 4'd2, 4'd1, 6, 32'b111100, 32'b000100, -1, "after_reset");
    idle_cycles(2, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
